// File: rtl/data_mem.sv
// Byte-addressed data memory for the single-cycle CPU: byte/half/word loads and
// stores with extension, sticky misalignment capture and a post-reset clear walk.
module data_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        LoadUnsigned,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        busy,
  output logic        alignErr,
  output logic [31:0] errAddr
);

  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH  = 2 ** WIDX_W;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [WIDX_W-1:0]   ptr_q, ptr_d;
  logic                align_err_q, align_err_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [31:0]         mem_q [DEPTH];

  logic [1:0]          lane;
  logic [WIDX_W-1:0]   widx;
  logic                legal;
  logic                ready;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         st_data;
  logic [3:0]          st_be;
  logic                mem_we;
  logic [WIDX_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_be;

  assign lane     = DAddr[1:0];
  assign widx     = DAddr[ADDR_WIDTH-1:2];
  assign ready    = (state_q == ST_READY);
  assign busy     = (state_q == ST_INIT);
  assign alignErr = align_err_q;
  assign errAddr  = err_addr_q;

  // Alignment legality per access size
  always_comb begin
    legal = 1'b0;
    case (MemSize)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~DAddr[0];
      2'b10:   legal = (lane == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Load path: lane select and extension, forced to zero unless a legal ready read
  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    DataOut = 32'h0000_0000;
    if (ready && MemRead && legal) begin
      case (MemSize)
        2'b00:   DataOut = LoadUnsigned ? {24'h00_0000, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
        2'b01:   DataOut = LoadUnsigned ? {16'h0000, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
        default: DataOut = rd_word;
      endcase
    end
  end

  // Store path: replicate sub-word data across lanes, byte enables pick the target
  always_comb begin
    st_data = DataIn;
    st_be   = 4'b1111;
    case (MemSize)
      2'b00: begin
        st_data = {4{DataIn[7:0]}};
        st_be   = 4'(4'b0001 << lane);
      end
      2'b01: begin
        st_data = {2{DataIn[15:0]}};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = DataIn;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Next-state, clear walk and error capture
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    align_err_d = align_err_q;
    err_addr_d  = err_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = widx;
    mem_wdata   = st_data;
    mem_be      = st_be;
    if (Reset) begin
      state_d     = ST_INIT;
      ptr_d       = '0;
      align_err_d = 1'b0;
      err_addr_d  = 32'h0000_0000;
    end else if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = INIT_VALUE;
      mem_be    = 4'b1111;
      ptr_d     = ptr_q + WIDX_W'(1);
      if (ptr_q == WIDX_W'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end else if (MemRead || MemWrite) begin
      if (!legal) begin
        align_err_d = 1'b1;
        if (!align_err_q) begin
          err_addr_d = DAddr;
        end
      end else if (MemWrite) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      align_err_q <= 1'b0;
      err_addr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      align_err_q <= align_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Array has no reset; only the clear walk or stores change it
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: clear walk, sub-word access, alignment faults,
// aliasing, mid-walk reset and same-cycle read/write.
module tb_data_mem;

  logic        CLK;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        LoadUnsigned;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        busy;
  logic        alignErr;
  logic [31:0] errAddr;

  int total = 0;
  int bad   = 0;

  data_mem dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .LoadUnsigned(LoadUnsigned), .DAddr(DAddr), .DataIn(DataIn),
    .DataOut(DataOut), .busy(busy), .alignErr(alignErr), .errAddr(errAddr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; one store consumes one rising edge
  task automatic idle();
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b10; LoadUnsigned = 1'b0;
    DAddr = 32'h0; DataIn = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    MemWrite = 1'b1; MemRead = 1'b0; DAddr = a; DataIn = d; MemSize = sz;
    @(posedge CLK); @(negedge CLK);
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    MemWrite = 1'b0; MemRead = 1'b1; DAddr = a; MemSize = sz; LoadUnsigned = uns;
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); n++;
      @(negedge CLK);
      if (!busy) break;
    end
  endtask

  task automatic reset_and_clear();
    int n;
    @(negedge CLK); Reset = 1'b1;
    @(posedge CLK); @(negedge CLK); Reset = 1'b0;
    wait_ready(n);
    total++;
    if (n !== 64) begin bad++; $display("FAIL clear_len got=%0d exp=64", n); end
  endtask

  task automatic test_reset();
    int n;
    idle();
    Reset = 1'b1; MemRead = 1'b1; DAddr = 32'h10;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (busy !== 1'b1 || alignErr !== 1'b0 || errAddr !== 32'h0) begin
      bad++; $display("FAIL reset_state busy=%b alignErr=%b errAddr=%h exp 1/0/0", busy, alignErr, errAddr);
    end
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL reset_dataout got=%h exp=0", DataOut); end
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); n++;
      @(negedge CLK);
      if (!busy) break;
      if (n == 10) begin
        total++;
        if (DataOut !== 32'h0) begin bad++; $display("FAIL busy_dataout got=%h exp=0", DataOut); end
        MemWrite = 1'b1; DAddr = 32'h0; DataIn = 32'hDEAD_BEEF; MemSize = 2'b10;
      end else if (n == 11) begin
        DAddr = 32'h5;
      end else if (n == 12) begin
        MemWrite = 1'b0; DAddr = 32'h10;
      end
    end
    total++;
    if (n !== 64) begin bad++; $display("FAIL busy_edges got=%0d exp=64", n); end
    load(32'h10, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL init_load10 got=%h exp=0", DataOut); end
    load(32'h0, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL busy_store_ignored got=%h exp=0", DataOut); end
    total++;
    if (alignErr !== 1'b0) begin bad++; $display("FAIL busy_no_err got=%b exp=0", alignErr); end
    idle();
  endtask

  task automatic test_word_access();
    store(32'h08, 32'h8765_4321, 2'b10);
    load(32'h08, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h8765_4321) begin bad++; $display("FAIL word_load got=%h exp=87654321", DataOut); end
    load(32'h08, 2'b10, 1'b1);
    total++;
    if (DataOut !== 32'h8765_4321) begin bad++; $display("FAIL word_load_uns got=%h exp=87654321", DataOut); end
    load(32'h0B, 2'b00, 1'b0);
    total++;
    if (DataOut !== 32'hFFFF_FF87) begin bad++; $display("FAIL byte_signed got=%h exp=ffffff87", DataOut); end
    load(32'h0B, 2'b00, 1'b1);
    total++;
    if (DataOut !== 32'h0000_0087) begin bad++; $display("FAIL byte_unsigned got=%h exp=00000087", DataOut); end
    load(32'h0A, 2'b01, 1'b0);
    total++;
    if (DataOut !== 32'hFFFF_8765) begin bad++; $display("FAIL half_signed got=%h exp=ffff8765", DataOut); end
    load(32'h08, 2'b00, 1'b0);
    total++;
    if (DataOut !== 32'h0000_0021) begin bad++; $display("FAIL byte0_signed got=%h exp=00000021", DataOut); end
    load(32'h08, 2'b01, 1'b0);
    total++;
    if (DataOut !== 32'h0000_4321) begin bad++; $display("FAIL half0_signed got=%h exp=00004321", DataOut); end
    idle();
  endtask

  task automatic test_subword_store();
    store(32'h09, 32'hAAAA_AA5C, 2'b00);
    load(32'h08, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h8765_5C21) begin bad++; $display("FAIL byte_store got=%h exp=87655c21", DataOut); end
    store(32'h0A, 32'h0000_BEEF, 2'b01);
    load(32'h08, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'hBEEF_5C21) begin bad++; $display("FAIL half_store got=%h exp=beef5c21", DataOut); end
    load(32'h0A, 2'b01, 1'b1);
    total++;
    if (DataOut !== 32'h0000_BEEF) begin bad++; $display("FAIL half_unsigned got=%h exp=0000beef", DataOut); end
    idle();
  endtask

  task automatic test_align_err();
    store(32'h0C, 32'h1111_1111, 2'b10);
    store(32'h10, 32'h2222_2222, 2'b10);
    store(32'h0E, 32'hFFFF_FFFF, 2'b10);
    total++;
    if (alignErr !== 1'b1 || errAddr !== 32'h0000_000E) begin
      bad++; $display("FAIL first_fault alignErr=%b errAddr=%h exp 1/0000000e", alignErr, errAddr);
    end
    load(32'h0C, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h1111_1111) begin bad++; $display("FAIL no_write_0c got=%h exp=11111111", DataOut); end
    load(32'h10, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h2222_2222) begin bad++; $display("FAIL no_write_10 got=%h exp=22222222", DataOut); end
    load(32'h11, 2'b01, 1'b0);
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL misaligned_half_out got=%h exp=0", DataOut); end
    @(posedge CLK); @(negedge CLK);
    total++;
    if (errAddr !== 32'h0000_000E || alignErr !== 1'b1) begin
      bad++; $display("FAIL second_fault errAddr=%h alignErr=%b exp 0000000e/1", errAddr, alignErr);
    end
    load(32'h20, 2'b11, 1'b0);
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL size11_out got=%h exp=0", DataOut); end
    @(posedge CLK); @(negedge CLK);
    total++;
    if (errAddr !== 32'h0000_000E) begin bad++; $display("FAIL size11_keep got=%h exp=0000000e", errAddr); end
    idle();
    reset_and_clear();
    total++;
    if (alignErr !== 1'b0 || errAddr !== 32'h0) begin
      bad++; $display("FAIL err_cleared alignErr=%b errAddr=%h exp 0/0", alignErr, errAddr);
    end
  endtask

  task automatic test_alias();
    store(32'h0000_0104, 32'h1234_5678, 2'b10);
    load(32'h04, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h1234_5678) begin bad++; $display("FAIL alias_load got=%h exp=12345678", DataOut); end
    total++;
    if (alignErr !== 1'b0) begin bad++; $display("FAIL alias_no_err got=%b exp=0", alignErr); end
    idle();
  endtask

  task automatic test_back_to_back();
    MemWrite = 1'b1; MemSize = 2'b00;
    for (int i = 0; i < 4; i++) begin
      DAddr = 32'h30 + 32'(i); DataIn = 32'hA0 + 32'(i);
      @(posedge CLK); @(negedge CLK);
    end
    MemWrite = 1'b0;
    load(32'h30, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'hA3A2_A1A0) begin bad++; $display("FAIL b2b_bytes got=%h exp=a3a2a1a0", DataOut); end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    store(32'h3C, 32'hCAFE_F00D, 2'b10);
    @(negedge CLK); Reset = 1'b1;
    @(posedge CLK); @(negedge CLK); Reset = 1'b0;
    repeat (29) @(posedge CLK);
    @(negedge CLK); Reset = 1'b1;
    @(posedge CLK); @(negedge CLK); Reset = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy got=%b exp=1", busy); end
    wait_ready(n);
    total++;
    if (n !== 64) begin bad++; $display("FAIL restart_len got=%0d exp=64", n); end
    load(32'h3C, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h0) begin bad++; $display("FAIL cleared_3c got=%h exp=0", DataOut); end
    store(32'h3C, 32'h1357_2468, 2'b10);
    load(32'h3C, 2'b10, 1'b0);
    total++;
    if (DataOut !== 32'h1357_2468) begin bad++; $display("FAIL store_3c got=%h exp=13572468", DataOut); end
    MemWrite = 1'b1; DataIn = 32'h0BAD_F00D;
    #1;
    total++;
    if (DataOut !== 32'h1357_2468) begin bad++; $display("FAIL rw_old got=%h exp=13572468", DataOut); end
    @(posedge CLK); @(negedge CLK);
    MemWrite = 1'b0;
    #1;
    total++;
    if (DataOut !== 32'h0BAD_F00D) begin bad++; $display("FAIL rw_new got=%h exp=0badf00d", DataOut); end
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    test_reset();
    test_word_access();
    test_subword_store();
    test_align_err();
    test_alias();
    test_back_to_back();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
